buzzer_seq: RTL and testbench
=============================

# buzzer_seq

Parametrised tone and burst generator driving a piezo buzzer output. It replaces the fixed single-tone buzzer with three additions: a run-time tone half-period, a burst mode (N beeps with programmable on/off lengths), and start/stop/done control. It sits between the board-level control FSM, which issues start/stop and config, and the buzzer pad.

## Interface
Parameters:
- CNT_W, 22, tone counter width; covers down to 20 Hz at 50 MHz.
- DUR_W, 16, width of the on/off length fields, counted in tone toggles.
- REP_W, 8, width of the burst repeat count.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  reset, synchronous, active-low.
- en_i  input  1  global enable; low forces return to IDLE.
- start_i  input  1  start request, sampled each cycle.
- stop_i  input  1  abort request.
- mode_i  input  1  0 = continuous tone, 1 = burst.
- half_i  input  CNT_W  tone half-period minus 1, in clk cycles.
- on_i  input  DUR_W  beep length in tone toggles; 0 is treated as 1.
- off_i  input  DUR_W  gap length in tone toggles; 0 means no gap.
- reps_i  input  REP_W  number of beeps; 0 is treated as 1.
- buzzer_o  output  1  registered tone output.
- busy_o  output  1  high while in ON or OFF.
- done_o  output  1  one-cycle pulse when a burst completes normally.

## Operation
- States: IDLE, ON, OFF.
- IDLE→ON when start_i & en_i & !stop_i.
  - On that edge, latch mode_i, half_i, on_i, off_i and reps_i into internal registers. Inputs are don't-care afterwards.
  - Clear the tone counter, toggle counter and rep counter. Set tone to 1.
- Timebase:
  - cnt increments every cycle in ON and OFF.
  - When cnt == half_q, cnt wraps to 0 and a toggle strobe fires.
  - One half-period is half_q+1 cycles. half_q=0 toggles every cycle.
- ON:
  - buzzer_o = tone. Each strobe inverts tone and increments tcnt.
  - Continuous mode: stay in ON until stop or !en_i.
  - Burst mode, strobe with tcnt == max(on_q,1)-1:
    - If this is the last rep, go to IDLE and assert done_o.
    - Else if off_q == 0, increment rep, clear tcnt and remain in ON with tone=1.
    - Else go to OFF and clear tcnt.
- OFF:
  - buzzer_o = 0 and tone is held at 0.
  - Strobe with tcnt == off_q-1: increment rep, clear tcnt, go to ON with tone=1 and cnt=0.
- stop_i or !en_i while busy: go to IDLE on the next edge. buzzer_o=0, no done_o.
- start_i while busy is ignored; there is no restart or queueing.
- stop_i and start_i together in IDLE: stop wins and nothing starts.

## Timing
- Reset (rst_n_i low at an edge): state=IDLE, all counters and latched config are 0, buzzer_o=0, busy_o=0, done_o=0.
- Start latency: with start accepted at edge k, busy_o=1 and buzzer_o=1 from cycle k+1.
- busy_o is registered and is high for exactly the ON and OFF cycles.
- done_o is high for one cycle: the first IDLE cycle after the final beep.
- Burst duration: reps·on·(half+1) + (reps−1)·off·(half+1) cycles, for on ≥ 1 and reps ≥ 1.
- The final beep has no trailing gap.
- All counters are unsigned. Compare with ==, never with >=.
- Latched config prevents mid-burst input changes from corrupting wrap points.

## Structure
- Package buzzer_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  - typedef enum logic {MODE_CONT, MODE_BURST} mode_t;
- Sub-module buzzer_tb_cnt (parameter CNT_W): counter with clear, run and half inputs, and a strobe output. The top level owns the FSM, tcnt, rep and tone registers.

## Test plan
- Reset while ON with half=3: assert rst_n_i=0 for one edge → next cycle buzzer_o=0, busy_o=0, done_o=0, state IDLE.
- Continuous, half=1: start → buzzer_o pattern 1,1,0,0,1,1… from cycle k+1 → stop_i → buzzer_o=0 and busy_o=0 the next cycle, no done_o.
- Burst, half=1, on=4, off=2, reps=3, start at edge 0:
  - busy_o high cycles 1–32.
  - Beeps at cycles 1–8, 13–20 and 25–32.
  - Gaps at cycles 9–12 and 21–24.
  - done_o=1 at cycle 33 only.
- Burst, half=0, on=0, off=0, reps=0: exactly 1 busy cycle with buzzer_o=1, then done_o.
- Mid-burst: drop en_i during OFF → IDLE next cycle, no done_o. Pulse start_i while busy → ignored, and the waveform matches the reference count.
- Simultaneous start_i and stop_i in IDLE → no start, busy_o stays 0.

Source files
------------

// File: rtl/buzzer_seq_pkg.sv
// Shared types for the buzzer tone/burst sequencer.
// State and mode encodings used by the top-level FSM.
package buzzer_seq_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;
  typedef enum logic {MODE_CONT, MODE_BURST} mode_t;

  // Length fields treat 0 as 1; returns the terminal count for an == compare.
  function automatic logic [15:0] last_of16(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

endpackage

// File: rtl/buzzer_tb_cnt.sv
// Tone timebase: counts 0..half and strobes on the wrap cycle.
// Strobe is combinational from the registered count; clear dominates run.
module buzzer_tb_cnt #(
  parameter int CNT_W = 22
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear,
  input  logic             run,
  input  logic [CNT_W-1:0] half,
  output logic             strobe
);

  logic [CNT_W-1:0] cnt_q;

  assign strobe = run && (cnt_q == half);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= strobe ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/buzzer_seq.sv
// Tone and burst generator for a piezo buzzer with start/stop/done control.
// Outputs are registered from next-state values, so busy/buzzer rise the cycle after start.
module buzzer_seq
  import buzzer_seq_pkg::*;
#(
  parameter int CNT_W = 22,
  parameter int DUR_W = 16,
  parameter int REP_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             mode_i,
  input  logic [CNT_W-1:0] half_i,
  input  logic [DUR_W-1:0] on_i,
  input  logic [DUR_W-1:0] off_i,
  input  logic [REP_W-1:0] reps_i,
  output logic             buzzer_o,
  output logic             busy_o,
  output logic             done_o
);

  state_t           state_q, state_d;
  mode_t            mode_q;
  logic [CNT_W-1:0] half_q;
  logic [DUR_W-1:0] on_q, off_q;
  logic [REP_W-1:0] reps_q;
  logic [DUR_W-1:0] tcnt_q, tcnt_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic             tone_q, tone_d;
  logic             done_d;
  logic             latch;
  logic             abort;
  logic             strobe;
  logic             buzzer_q, busy_q, done_q;

  logic [DUR_W-1:0] on_last, off_last;
  logic [REP_W-1:0] rep_last;

  assign on_last  = (on_q == '0) ? '0 : on_q - DUR_W'(1);
  assign off_last = off_q - DUR_W'(1);
  assign rep_last = (reps_q == '0) ? '0 : reps_q - REP_W'(1);
  assign abort    = !en_i || stop_i;

  // Counter is held at zero in IDLE so every beep and gap starts on a fresh period.
  buzzer_tb_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clear   (state_q == IDLE),
    .run     (state_q != IDLE),
    .half    (half_q),
    .strobe  (strobe)
  );

  always_comb begin
    state_d = state_q;
    tone_d  = tone_q;
    tcnt_d  = tcnt_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && en_i && !stop_i) begin
          state_d = ON;
          tone_d  = 1'b1;
          tcnt_d  = '0;
          rep_d   = '0;
          latch   = 1'b1;
        end
      end
      ON: begin
        if (abort) begin
          state_d = IDLE;
          tone_d  = 1'b0;
        end else if (strobe) begin
          if (mode_q == MODE_BURST && tcnt_q == on_last) begin
            tcnt_d = '0;
            if (rep_q == rep_last) begin
              state_d = IDLE;
              tone_d  = 1'b0;
              done_d  = 1'b1;
            end else if (off_q == '0) begin
              rep_d  = rep_q + REP_W'(1);
              tone_d = 1'b1;
            end else begin
              state_d = OFF;
              tone_d  = 1'b0;
            end
          end else begin
            tone_d = ~tone_q;
            tcnt_d = tcnt_q + DUR_W'(1);
          end
        end
      end
      OFF: begin
        if (abort) begin
          state_d = IDLE;
          tone_d  = 1'b0;
        end else if (strobe) begin
          if (tcnt_q == off_last) begin
            state_d = ON;
            tone_d  = 1'b1;
            tcnt_d  = '0;
            rep_d   = rep_q + REP_W'(1);
          end else begin
            tcnt_d = tcnt_q + DUR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tone_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      mode_q   <= MODE_CONT;
      half_q   <= '0;
      on_q     <= '0;
      off_q    <= '0;
      reps_q   <= '0;
      tcnt_q   <= '0;
      rep_q    <= '0;
      tone_q   <= 1'b0;
      buzzer_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      rep_q    <= rep_d;
      tone_q   <= tone_d;
      buzzer_q <= (state_d == ON) && tone_d;
      busy_q   <= (state_d != IDLE);
      done_q   <= done_d;
      if (latch) begin
        mode_q <= mode_t'(mode_i);
        half_q <= half_i;
        on_q   <= on_i;
        off_q  <= off_i;
        reps_q <= reps_i;
      end
    end
  end

  assign buzzer_o = buzzer_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_buzzer_seq.sv
// Randomised bench for buzzer_seq against a waveform-level reference model.
// Expected buzzer sequences are built from beep/gap arithmetic, not FSM state.
module tb_buzzer_seq;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        en_i;
  logic        start_i;
  logic        stop_i;
  logic        mode_i;
  logic [21:0] half_i;
  logic [15:0] on_i;
  logic [15:0] off_i;
  logic [7:0]  reps_i;
  logic        buzzer_o;
  logic        busy_o;
  logic        done_o;

  int errors = 0;
  int checks = 0;
  bit exp_q[$];

  always #5 clk_i = ~clk_i;

  buzzer_seq dut (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .en_i     (en_i),
    .start_i  (start_i),
    .stop_i   (stop_i),
    .mode_i   (mode_i),
    .half_i   (half_i),
    .on_i     (on_i),
    .off_i    (off_i),
    .reps_i   (reps_i),
    .buzzer_o (buzzer_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected buzzer level for every busy cycle of a complete burst.
  task automatic build_burst(input int h, input int on, input int off, input int reps);
    int on_e, reps_e;
    exp_q.delete();
    on_e   = (on == 0) ? 1 : on;
    reps_e = (reps == 0) ? 1 : reps;
    for (int r = 0; r < reps_e; r++) begin
      for (int t = 0; t < on_e; t++)
        for (int c = 0; c <= h; c++) exp_q.push_back((t % 2) == 0);
      if (r != reps_e - 1)
        for (int c = 0; c < off * (h + 1); c++) exp_q.push_back(1'b0);
    end
  endtask

  task automatic check3(input string name, input bit eb, input bit ebusy, input bit edone);
    checks++;
    if (buzzer_o !== eb || busy_o !== ebusy || done_o !== edone) begin
      errors++;
      $display("FAIL %s @%0t: buzzer/busy/done got %b%b%b expected %b%b%b",
               name, $time, buzzer_o, busy_o, done_o, eb, ebusy, edone);
    end
  endtask

  task automatic start(input bit mode, input int h, input int on, input int off, input int reps);
    mode_i  = mode;
    half_i  = 22'(h);
    on_i    = 16'(on);
    off_i   = 16'(off);
    reps_i  = 8'(reps);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic idle_inputs();
    start_i = 1'b0;
    stop_i  = 1'b0;
    en_i    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    idle_inputs();
    mode_i = 1'b0; half_i = '0; on_i = '0; off_i = '0; reps_i = '0;
    tick(); tick();
    check3("reset_state", 1'b0, 1'b0, 1'b0);
    rst_n_i = 1'b1;
    tick();
    check3("idle_after_reset", 1'b0, 1'b0, 1'b0);
    start(1'b0, 3, 1, 1, 1);
    check3("reset_prep_on", 1'b1, 1'b1, 1'b0);
    tick(); tick(); tick(); tick();
    check3("reset_prep_second_half", 1'b0, 1'b1, 1'b0);
    rst_n_i = 1'b0;
    tick();
    check3("reset_while_on", 1'b0, 1'b0, 1'b0);
    rst_n_i = 1'b1;
    tick();
    check3("reset_stays_idle", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_continuous();
    idle_inputs();
    start(1'b0, 1, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      check3("cont_pattern", ((i / 2) % 2) == 0, 1'b1, 1'b0);
      half_i = 22'($urandom_range(0, 7));
      tick();
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    check3("cont_stop", 1'b0, 1'b0, 1'b0);
    tick();
    check3("cont_stop_no_done", 1'b0, 1'b0, 1'b0);
  endtask

  // Runs a whole burst; optionally pulses start_i and scrambles inputs while busy.
  task automatic run_burst(input string name, input int h, input int on, input int off,
                           input int reps, input bit noisy);
    int n;
    idle_inputs();
    build_burst(h, on, off, reps);
    n = exp_q.size();
    start(1'b1, h, on, off, reps);
    for (int i = 0; i < n; i++) begin
      check3(name, exp_q[i], 1'b1, 1'b0);
      if (noisy) begin
        start_i = ($urandom_range(0, 3) == 0);
        mode_i  = 1'($urandom);
        half_i  = 22'($urandom_range(0, 5));
        on_i    = 16'($urandom_range(0, 6));
        off_i   = 16'($urandom_range(0, 6));
        reps_i  = 8'($urandom_range(0, 6));
      end
      tick();
    end
    start_i = 1'b0;
    check3({name, "_done"}, 1'b0, 1'b0, 1'b1);
    tick();
    check3({name, "_done_once"}, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_burst_directed();
    run_burst("burst_1_4_2_3", 1, 4, 2, 3, 1'b0);
    checks++;
    if (exp_q.size() != 32) begin
      errors++;
      $display("FAIL burst_len: model length %0d expected 32", exp_q.size());
    end
    run_burst("burst_min", 0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back_random();
    for (int k = 0; k < 12; k++)
      run_burst("burst_rand", $urandom_range(0, 3), $urandom_range(0, 5),
                $urandom_range(0, 3), $urandom_range(0, 4), 1'b1);
  endtask

  task automatic test_abort_off();
    idle_inputs();
    // h=1, on=2: ON spans cycles 1-4, the gap spans cycles 5-10.
    start(1'b1, 1, 2, 3, 3);
    for (int i = 1; i <= 6; i++) begin
      check3("abort_pre", (i <= 4) && (((i - 1) / 2) % 2 == 0), 1'b1, 1'b0);
      tick();
    end
    en_i = 1'b0;
    check3("abort_in_off", 1'b0, 1'b1, 1'b0);
    tick();
    check3("abort_idle", 1'b0, 1'b0, 1'b0);
    en_i = 1'b1;
    tick();
    check3("abort_no_done", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_start_stop();
    idle_inputs();
    stop_i = 1'b1;
    start(1'b1, 1, 2, 2, 2);
    stop_i = 1'b0;
    check3("start_stop_idle", 1'b0, 1'b0, 1'b0);
    tick();
    check3("start_stop_still_idle", 1'b0, 1'b0, 1'b0);
    en_i = 1'b0;
    start(1'b0, 1, 1, 1, 1);
    en_i = 1'b1;
    check3("start_disabled", 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_burst_directed();
    test_abort_off();
    test_start_stop();
    test_back_to_back_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
